// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its stall/flush controller.
// The controller takes the slave side; the datapath (or a bench) drives the master side.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    // Hazard and memory-handshake events into the controller
    logic             ld_use;
    logic             br_taken;
    logic             imem_stall;
    logic             imem_done;
    logic             dmem_stall;
    logic             dmem_done;
    logic             halt_wb;

    // Pipeline register control and status out of the controller
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_bubble;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             halted;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ld_use, br_taken, imem_stall, imem_done, dmem_stall, dmem_done, halt_wb,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_bubble, idex_bubble, exmem_bubble, halted, state, stall_cnt
    );

    modport slave (
        input  ld_use, br_taken, imem_stall, imem_done, dmem_stall, dmem_done, halt_wb,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_bubble, idex_bubble, exmem_bubble, halted, state, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: sequences load-use, branch, imem and dmem waits
// and halt, and counts cycles in which the PC was frozen outside HALT.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IWAIT = 2'd1,
        DWAIT = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic             i_pend_reg, i_pend_next;
    logic [CNT_W-1:0] cnt_reg;

    // en = {pc, ifid, idex, exmem, memwb}; bub = {ifid, idex, exmem}
    logic [4:0]       en;
    logic [2:0]       bub;
    logic [2:0]       bub_gated;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= RUN;
            i_pend_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            i_pend_reg <= i_pend_next;
            if (!en[4] && (state_reg != HALT) && (cnt_reg != '1))
                cnt_reg <= cnt_reg + CNT_ONE;
        end
    end

    always_comb begin
        state_next  = state_reg;
        i_pend_next = i_pend_reg;
        en          = 5'b11111;
        bub         = 3'b000;

        unique case (state_reg)
            RUN: begin
                if (bus.halt_wb) begin
                    en          = 5'b00000;
                    i_pend_next = 1'b0;
                    state_next  = HALT;
                end else if (bus.dmem_stall) begin
                    en          = 5'b00000;
                    i_pend_next = bus.imem_stall;
                    state_next  = DWAIT;
                end else if (bus.br_taken) begin
                    bub = 3'b110;
                end else if (bus.imem_stall) begin
                    en[4]      = 1'b0;
                    bub        = 3'b100;
                    state_next = IWAIT;
                end else if (bus.ld_use) begin
                    en[4] = 1'b0;
                    en[3] = 1'b0;
                    bub   = 3'b010;
                end
            end

            IWAIT: begin
                if (bus.halt_wb) begin
                    en          = 5'b00000;
                    i_pend_next = 1'b0;
                    state_next  = HALT;
                end else if (bus.dmem_stall) begin
                    en          = 5'b00000;
                    i_pend_next = bus.imem_stall;
                    state_next  = DWAIT;
                end else if (bus.br_taken) begin
                    // Branch parks in EX; a fetch completing now is discarded since
                    // the branch redirects the PC once back in RUN.
                    en  = 5'b00011;
                    bub = 3'b001;
                    if (bus.imem_done)
                        state_next = RUN;
                end else if (bus.imem_done) begin
                    state_next = RUN;
                end else begin
                    en[4] = 1'b0;
                    bub   = 3'b100;
                end
            end

            DWAIT: begin
                en = 5'b00000;
                if (bus.halt_wb) begin
                    i_pend_next = 1'b0;
                    state_next  = HALT;
                end else begin
                    if (bus.imem_done)
                        i_pend_next = 1'b0;
                    if (bus.dmem_done) begin
                        en          = 5'b11111;
                        i_pend_next = 1'b0;
                        state_next  = (i_pend_reg && !bus.imem_done) ? IWAIT : RUN;
                    end
                end
            end

            HALT: begin
                en = 5'b00000;
            end

            default: begin
                en = 5'b00000;
            end
        endcase
    end

    // A bubble is only meaningful while its register actually loads.
    for (genvar gi = 0; gi < 3; gi++) begin : g_bub
        assign bub_gated[gi] = bub[gi] & en[gi+1];
    end

    assign bus.pc_en        = en[4];
    assign bus.ifid_en      = en[3];
    assign bus.idex_en      = en[2];
    assign bus.exmem_en     = en[1];
    assign bus.memwb_en     = en[0];
    assign bus.ifid_bubble  = bub_gated[2];
    assign bus.idex_bubble  = bub_gated[1];
    assign bus.exmem_bubble = bub_gated[0];
    assign bus.halted       = (state_reg == HALT);
    assign bus.state        = state_reg;
    assign bus.stall_cnt    = cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl; a second narrow-counter instance covers saturation.
module tb_pipe_ctrl;

    localparam logic [6:0] I_NONE = 7'h00;
    localparam logic [6:0] I_LD   = 7'h01;
    localparam logic [6:0] I_BR   = 7'h02;
    localparam logic [6:0] I_IS   = 7'h04;
    localparam logic [6:0] I_ID   = 7'h08;
    localparam logic [6:0] I_DS   = 7'h10;
    localparam logic [6:0] I_DD   = 7'h20;
    localparam logic [6:0] I_HW   = 7'h40;

    localparam logic [4:0] E_ALL  = 5'b11111;
    localparam logic [4:0] E_NONE = 5'b00000;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_IWAIT = 2'd1;
    localparam logic [1:0] S_DWAIT = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    pipe_ctrl_if #(.CNT_W(16)) bus   ();
    pipe_ctrl_if #(.CNT_W(2))  bus_s ();

    pipe_ctrl #(.CNT_W(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    pipe_ctrl #(.CNT_W(2))  dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One pipeline cycle: drive inputs, check this cycle's outputs, then take the edge.
    task automatic cyc(input string tag, input logic [6:0] in,
                       input logic [4:0] exp_en, input logic [2:0] exp_bub,
                       input logic [1:0] exp_st);
        {bus.halt_wb, bus.dmem_done, bus.dmem_stall, bus.imem_done,
         bus.imem_stall, bus.br_taken, bus.ld_use} = in;
        #1;
        $display("[TB] %-10s in=%07b en=%05b bub=%03b st=%0d cnt=%0d", tag, in,
                 {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en},
                 {bus.ifid_bubble, bus.idex_bubble, bus.exmem_bubble},
                 bus.state, bus.stall_cnt);
        check({tag, ".st"},  32'(bus.state), 32'(exp_st));
        check({tag, ".en"},  32'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}),
              32'(exp_en));
        check({tag, ".bub"}, 32'({bus.ifid_bubble, bus.idex_bubble, bus.exmem_bubble}), 32'(exp_bub));
        check({tag, ".hlt"}, 32'(bus.halted), 32'(exp_st == S_HALT));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        {bus.halt_wb, bus.dmem_done, bus.dmem_stall, bus.imem_done,
         bus.imem_stall, bus.br_taken, bus.ld_use} = I_NONE;
        rst_n = 1'b0;
        #1;
        check({tag, ".st"},  32'(bus.state), 32'(S_RUN));
        check({tag, ".cnt"}, 32'(bus.stall_cnt), 32'd0);
        check({tag, ".hlt"}, 32'(bus.halted), 32'd0);
        check({tag, ".en"},  32'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}),
              32'(E_ALL));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        {bus_s.halt_wb, bus_s.dmem_done, bus_s.dmem_stall, bus_s.imem_done,
         bus_s.imem_stall, bus_s.br_taken, bus_s.ld_use} = I_NONE;
        rst_n = 1'b1;
        #1;
        do_reset("rst0");

        // Idle after reset
        for (int i = 0; i < 10; i++) cyc("idle", I_NONE, E_ALL, 3'b000, S_RUN);
        check("idle.cnt", 32'(bus.stall_cnt), 32'd0);

        // Single load-use stall
        cyc("lduse", I_LD, 5'b00111, 3'b010, S_RUN);
        check("lduse.cnt", 32'(bus.stall_cnt), 32'd1);
        cyc("post_ld", I_NONE, E_ALL, 3'b000, S_RUN);

        // dmem wait of three cycles, done in the fourth
        cyc("ds1", I_DS, E_NONE, 3'b000, S_RUN);
        cyc("ds2", I_DS, E_NONE, 3'b000, S_DWAIT);
        cyc("ds3", I_DS, E_NONE, 3'b000, S_DWAIT);
        cyc("dd",  I_DD, E_ALL,  3'b000, S_DWAIT);
        cyc("post_dd", I_NONE, E_ALL, 3'b000, S_RUN);
        check("dwait.cnt", 32'(bus.stall_cnt), 32'd4);

        // imem+dmem stall, imem completes inside DWAIT: no IWAIT visit
        cyc("is_ds", I_IS | I_DS, E_NONE, 3'b000, S_RUN);
        cyc("dw_id", I_ID, E_NONE, 3'b000, S_DWAIT);
        cyc("dw_dd", I_DD, E_ALL, 3'b000, S_DWAIT);
        cyc("no_iwait", I_NONE, E_ALL, 3'b000, S_RUN);
        check("both.cnt", 32'(bus.stall_cnt), 32'd6);

        // imem still pending at dmem_done: detour via IWAIT, branch held there
        cyc("is_ds2", I_IS | I_DS, E_NONE, 3'b000, S_RUN);
        cyc("dd_pend", I_DD, E_ALL, 3'b000, S_DWAIT);
        cyc("iw_wait", I_NONE, 5'b01111, 3'b100, S_IWAIT);
        cyc("iw_br", I_BR, 5'b00011, 3'b001, S_IWAIT);
        cyc("iw_id", I_ID, E_ALL, 3'b000, S_IWAIT);
        cyc("iw_back", I_NONE, E_ALL, 3'b000, S_RUN);
        check("pend.cnt", 32'(bus.stall_cnt), 32'd9);

        // Both done pulses together in DWAIT
        cyc("is_ds3", I_IS | I_DS, E_NONE, 3'b000, S_RUN);
        cyc("id_dd", I_ID | I_DD, E_ALL, 3'b000, S_DWAIT);
        cyc("sim_back", I_NONE, E_ALL, 3'b000, S_RUN);
        check("sim.cnt", 32'(bus.stall_cnt), 32'd10);

        // Plain imem stall from RUN
        cyc("is1", I_IS, 5'b01111, 3'b100, S_RUN);
        cyc("is2", I_IS, 5'b01111, 3'b100, S_IWAIT);
        cyc("is_id", I_ID, E_ALL, 3'b000, S_IWAIT);
        cyc("is_back", I_NONE, E_ALL, 3'b000, S_RUN);
        check("imem.cnt", 32'(bus.stall_cnt), 32'd12);

        // Branch beats load-use
        cyc("br_ld", I_BR | I_LD, E_ALL, 3'b110, S_RUN);
        check("br.cnt", 32'(bus.stall_cnt), 32'd12);

        // dmem_stall beats br/imem/ld_use
        cyc("prio", I_DS | I_BR | I_IS | I_LD, E_NONE, 3'b000, S_RUN);
        cyc("prio_dd", I_DD, E_ALL, 3'b000, S_DWAIT);
        cyc("prio_id", I_ID, E_ALL, 3'b000, S_IWAIT);
        cyc("prio_back", I_NONE, E_ALL, 3'b000, S_RUN);
        check("prio.cnt", 32'(bus.stall_cnt), 32'd13);

        // Reset in the middle of a dmem wait; stale done pulses ignored
        cyc("ds_pre", I_DS, E_NONE, 3'b000, S_RUN);
        do_reset("rst_dw");
        cyc("stale_dd", I_DD, E_ALL, 3'b000, S_RUN);
        cyc("stale_id", I_ID, E_ALL, 3'b000, S_RUN);
        check("stale.cnt", 32'(bus.stall_cnt), 32'd0);

        // Halt from RUN, sticky until reset
        cyc("hw", I_HW, E_NONE, 3'b000, S_RUN);
        for (int i = 0; i < 3; i++) cyc("halt", I_NONE, E_NONE, 3'b000, S_HALT);
        cyc("halt_ev", I_DS | I_DD | I_ID | I_BR, E_NONE, 3'b000, S_HALT);
        check("halt.cnt", 32'(bus.stall_cnt), 32'd1);
        do_reset("rst_hlt");
        cyc("post_hlt", I_NONE, E_ALL, 3'b000, S_RUN);

        // Halt beats dmem_done in DWAIT
        cyc("ds_h", I_DS, E_NONE, 3'b000, S_RUN);
        cyc("hw_dd", I_HW | I_DD, E_NONE, 3'b000, S_DWAIT);
        cyc("halt2", I_NONE, E_NONE, 3'b000, S_HALT);
        check("halt2.cnt", 32'(bus.stall_cnt), 32'd2);
        do_reset("rst_h2");

        // Narrow counter saturates at all-ones
        check("sat.start", 32'(bus_s.stall_cnt), 32'd0);
        bus_s.ld_use = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            $display("[TB] sat        k=%0d cnt=%0d", k, bus_s.stall_cnt);
            check("sat", 32'(bus_s.stall_cnt), (k > 3) ? 32'd3 : 32'(k));
        end
        bus_s.ld_use = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-002 The block SHALL have port clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port ld_use  input  1  load-use hazard on the ID/EX instruction (the forwarding unit's exex_stall).
REQ-005 The block SHALL have port br_taken  input  1  taken branch/jump resolved in EX this cycle.
REQ-006 The block SHALL have port imem_stall  input  1  instruction memory busy (level).
REQ-007 The block SHALL have port imem_done  input  1  one-cycle pulse, fetch data valid.
REQ-008 The block SHALL have port dmem_stall  input  1  data memory busy (level).
REQ-009 The block SHALL have port dmem_done  input  1  one-cycle pulse, data access complete.
REQ-010 The block SHALL have port halt_wb  input  1  HALT instruction in MEM/WB.
REQ-011 The block SHALL have ports pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  register load enables.
REQ-012 The block SHALL have ports ifid_bubble, idex_bubble, exmem_bubble  output  1 each  load NOP (16'b0000100000000000, control zero) instead of upstream value.
REQ-013 The block SHALL have port halted  output  1  processor halted.
REQ-014 The block SHALL have port state  output  2  RUN=0, IWAIT=1, DWAIT=2, HALT=3.
REQ-015 The block SHALL have port stall_cnt  output  CNT_W  cycles with pc_en=0 outside HALT.

Function
REQ-016 FSM states RUN, IWAIT, DWAIT, HALT; one internal flag i_pend; all outputs except stall_cnt/state combinational from state and inputs.
REQ-017 RUN, no events: all five enables 1, all bubbles 0.
REQ-018 Priority of events, highest first: halt_wb, dmem_stall, br_taken, imem_stall, ld_use.
REQ-019 halt_wb in any state other than HALT -> HALT next cycle; in HALT all enables 0, bubbles 0, halted=1; leaves only via reset.
REQ-020 dmem_stall in RUN or IWAIT -> all enables 0 this cycle, next state DWAIT; i_pend set if imem_stall is also high.
REQ-021 DWAIT: all enables 0, bubbles 0; i_pend cleared on imem_done.
REQ-022 dmem_done in DWAIT: all enables 1 this cycle; next state IWAIT if i_pend still set and imem_done not seen in that cycle, else RUN.
REQ-023 br_taken in RUN: pc_en=1 (target load), ifid_bubble=1, idex_bubble=1, other enables 1; ld_use ignored that cycle.
REQ-024 imem_stall in RUN (no dmem_stall): pc_en=0, ifid_en=1 with ifid_bubble=1, back stages enabled; next state IWAIT.
REQ-025 IWAIT: pc_en=0, ifid_en=1 with ifid_bubble=1, idex/exmem/memwb enabled; imem_done -> pc_en=1, ifid_bubble=0 that cycle, next RUN.
REQ-026 br_taken in IWAIT: idex_en=0, ifid_en=0, exmem_bubble=1; branch held in EX and resolved per REQ-023 after return to RUN.
REQ-027 ld_use in RUN (lowest priority): pc_en=0, ifid_en=0, idex_bubble=1, exmem_en/memwb_en=1; no state change; repeats while ld_use high.
REQ-028 imem_done and dmem_done simultaneous in DWAIT: go to RUN, i_pend cleared.
REQ-029 stall_cnt increments by 1 on each edge where pc_en=0 and state!=HALT; saturates at all-ones, never wraps.
REQ-030 Any bubble output SHALL be asserted only with its matching enable at 1.

Reset
REQ-031 rst_n low asynchronously forces state=RUN, i_pend=0, stall_cnt=0; with inputs 0 outputs read all enables 1, bubbles 0, halted 0.
REQ-032 Reset asserted mid-DWAIT/IWAIT/HALT SHALL abort the wait immediately; pending done pulses after release are ignored in RUN.

Verification
REQ-033 Reset release, idle inputs 10 cycles -> state=0, all enables 1, stall_cnt=0.
REQ-034 ld_use high 1 cycle in RUN -> pc_en=0, ifid_en=0, idex_bubble=1 that cycle only; stall_cnt=1.
REQ-035 dmem_stall high 3 cycles, dmem_done in 4th -> state=2 for 3 cycles, enables 0 for 3 cycles, 1 in 4th, then RUN; stall_cnt=4.
REQ-036 imem_stall and dmem_stall together, imem_done during DWAIT, then dmem_done -> DWAIT then RUN with no IWAIT visit.
REQ-037 br_taken and ld_use same cycle in RUN -> pc_en=1, ifid_bubble=1, idex_bubble=1.
REQ-038 halt_wb then rst_n low for 1 cycle -> halted=1, state=3 until reset; after reset state=0, halted=0, stall_cnt=0; stall_cnt forced near max saturates at all-ones.
